reg_mem_xfer_ctrl: RTL

- Sequencer for the CHIP-8 block register/memory transfer opcodes Fx55 and Fx65.
- Fx55 stores V0..Vx to memory at I. Fx65 loads V0..Vx from memory at I.
- Sits between the instruction decoder, the CPU register file (x-select, Vx read, Vx write, I write) and the shared 4 KB memory port, using a req/ack handshake.
- Runs one register per beat and optionally updates I afterwards.

---
 rtl/reg_mem_xfer_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_mem_xfer_ctrl.sv
// Sequences CHIP-8 Fx55/Fx65 block transfers: one register per memory beat, then optional I update.
// Latency 2(x+1)+1 cycles at zero-wait; each XFER cycle without mem_ack stretches the beat; start is ignored while busy.
module reg_mem_xfer_ctrl #(
  parameter int I_INCREMENT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_load,
  input  logic [3:0]  last_x,
  input  logic [15:0] i_rd,
  output logic [3:0]  x_sel,
  input  logic [7:0]  vx,
  output logic        wx,
  output logic [7:0]  nx,
  output logic        i_en,
  output logic [15:0] i_wr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, XFER, STEP, FIN} state_t;

  state_t      state;
  logic        op;
  logic [3:0]  lx;
  logic [3:0]  idx;
  logic [15:0] base;
  logic [3:0]  idx_nxt;

  assign idx_nxt = idx + 4'd1;

  // Vx follows x_sel combinationally, so store data is taken straight from the register file.
  assign mem_wdata = (mem_req && mem_we) ? vx : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= 1'b0;
      lx       <= 4'd0;
      idx      <= 4'd0;
      base     <= 16'd0;
      x_sel    <= 4'd0;
      wx       <= 1'b0;
      nx       <= 8'd0;
      i_en     <= 1'b0;
      i_wr     <= 16'd0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 12'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wx   <= 1'b0;
      i_en <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op       <= op_load;
            lx       <= last_x;
            base     <= i_rd;
            idx      <= 4'd0;
            x_sel    <= 4'd0;
            mem_req  <= 1'b1;
            mem_we   <= ~op_load;
            mem_addr <= i_rd[11:0];
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (op) begin
              wx <= 1'b1;
              nx <= mem_rdata;
            end
            state <= STEP;
          end
        end
        STEP: begin
          if (idx == lx) begin
            done <= 1'b1;
            if (I_INCREMENT != 0) begin
              i_en <= 1'b1;
              i_wr <= base + {12'd0, lx} + 16'd1;
            end
            state <= FIN;
          end else begin
            idx      <= idx_nxt;
            x_sel    <= idx_nxt;
            mem_req  <= 1'b1;
            mem_we   <= ~op;
            mem_addr <= base[11:0] + {8'd0, idx_nxt};
            state    <= XFER;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          x_sel <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
